// File: rtl/bw_r_irf_pkg.sv
// Shared types and helpers for the IRF window swap controller.
// Address layout is {tid, win} into the window backing store.
package bw_r_irf_pkg;

    localparam int IRF_TID_W  = 2;
    localparam int IRF_WIN_W  = 3;
    localparam int IRF_ADDR_W = IRF_TID_W + IRF_WIN_W;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        GAP,
        RESTORE,
        DONE
    } swap_state_e;

    function automatic logic [IRF_ADDR_W-1:0] irf_addr(
        input logic [IRF_TID_W-1:0] tid,
        input logic [IRF_WIN_W-1:0] win
    );
        return {tid, win};
    endfunction

endpackage

// File: rtl/bw_r_irf_swap_if.sv
// Request/strobe bundle between the trap logic, the swap
// controller and the IRF register array.
interface bw_r_irf_swap_if #(
    parameter int BANKS = 2,
    parameter int TID_W = 2,
    parameter int WIN_W = 3
);
    logic                   swp_req_vld;
    logic                   swp_req_rdy;
    logic [TID_W-1:0]       swp_tid;
    logic [WIN_W-1:0]       swp_old_win;
    logic [WIN_W-1:0]       swp_new_win;
    logic                   swp_kill;
    logic                   irf_save;
    logic                   irf_restore;
    logic [TID_W+WIN_W-1:0] irf_save_addr;
    logic [TID_W+WIN_W-1:0] irf_restore_addr;
    logic [BANKS-1:0]       irf_bank_sel;
    logic                   swp_done;
    logic                   swp_aborted;
    logic [TID_W-1:0]       swp_done_tid;
    logic [2**TID_W-1:0]    swp_busy_tid;

    modport master (
        input  swp_req_vld, swp_tid, swp_old_win,
        input  swp_new_win, swp_kill,
        output swp_req_rdy, irf_save, irf_restore,
        output irf_save_addr, irf_restore_addr,
        output irf_bank_sel, swp_done, swp_aborted,
        output swp_done_tid, swp_busy_tid
    );

    modport slave (
        output swp_req_vld, swp_tid, swp_old_win,
        output swp_new_win, swp_kill,
        input  swp_req_rdy, irf_save, irf_restore,
        input  irf_save_addr, irf_restore_addr,
        input  irf_bank_sel, swp_done, swp_aborted,
        input  swp_done_tid, swp_busy_tid
    );

endinterface

// File: rtl/bw_r_irf_swap_bank_cnt.sv
// Bank sweep counter shared by the save and restore phases;
// wraps to zero after the last bank.
module bw_r_irf_swap_bank_cnt #(
    parameter int BANKS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic             last,
    output logic [BANKS-1:0] onehot
);
    localparam int CW = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic [CW-1:0] cnt;

    assign last   = (cnt == CW'(BANKS - 1));
    assign onehot = BANKS'(1) << cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bw_r_irf_swap_ctl.sv
// IRF window swap sequencer: save sweep, one gap cycle,
// restore sweep, then a single done pulse.
module bw_r_irf_swap_ctl
    import bw_r_irf_pkg::*;
#(
    parameter int BANKS = 2,
    parameter int TID_W = IRF_TID_W,
    parameter int WIN_W = IRF_WIN_W
) (
    input  logic             clk,
    input  logic             reset,
    bw_r_irf_swap_if.master  bus
);
    localparam int NT = 2**TID_W;

    swap_state_e      state;
    swap_state_e      nxt;
    logic [TID_W-1:0] tid_q;
    logic [WIN_W-1:0] old_q;
    logic [WIN_W-1:0] new_q;
    logic             abort_q;
    logic             accept;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_last;
    logic             kill_abort;
    logic             active;
    logic             strobe;
    logic [BANKS-1:0] bank_oh;

    bw_r_irf_swap_bank_cnt #(.BANKS(BANKS)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .last   (cnt_last),
        .onehot (bank_oh)
    );

    assign bus.swp_req_rdy = (state == IDLE) && !bus.swp_kill;
    assign accept = bus.swp_req_vld && bus.swp_req_rdy;

    // Kill is honoured only once the save sweep has fully landed.
    always_comb begin
        nxt        = state;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        kill_abort = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_clr = 1'b1;
                    if (bus.swp_old_win == bus.swp_new_win)
                        nxt = DONE;
                    else
                        nxt = SAVE;
                end
            end
            SAVE: begin
                cnt_en = 1'b1;
                if (cnt_last) nxt = GAP;
            end
            GAP: begin
                kill_abort = bus.swp_kill;
                nxt = bus.swp_kill ? DONE : RESTORE;
            end
            RESTORE: begin
                if (bus.swp_kill) begin
                    kill_abort = 1'b1;
                    cnt_clr    = 1'b1;
                    nxt        = DONE;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_last) nxt = DONE;
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                nxt     = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tid_q   <= '0;
            old_q   <= '0;
            new_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                tid_q   <= bus.swp_tid;
                old_q   <= bus.swp_old_win;
                new_q   <= bus.swp_new_win;
                abort_q <= 1'b0;
            end else if (kill_abort) begin
                abort_q <= 1'b1;
            end
        end
    end

    assign active = (state != IDLE);
    assign strobe = (state == SAVE) || (state == RESTORE);

    assign bus.irf_save     = (state == SAVE);
    assign bus.irf_restore  = (state == RESTORE);
    assign bus.irf_bank_sel = strobe ? bank_oh : '0;

    assign bus.irf_save_addr =
        active ? irf_addr(tid_q, old_q) : '0;
    assign bus.irf_restore_addr =
        active ? irf_addr(tid_q, new_q) : '0;

    assign bus.swp_done     = (state == DONE);
    assign bus.swp_aborted  = (state == DONE) && abort_q;
    assign bus.swp_done_tid = (state == DONE) ? tid_q : '0;
    assign bus.swp_busy_tid = active ? (NT'(1) << tid_q) : '0;

endmodule

// File: doc/bw_r_irf_swap_ctl.md
Name: bw_r_irf_swap_ctl

Overview:
Initiator-side sequencer for the IRF window save/restore protocol. On a window-change request (thread, old window, new window), it drives save strobes that copy the active registers into the window backing store, then restore strobes that load the new window back. Register banks are swept one per cycle. It sits between the trap/window logic and the array of IRF registers, and gives the pipeline a per-thread busy mask and a completion pulse.

Parameters:
BANKS, 2, number of register banks swept sequentially (1..8)
TID_W, 2, thread id width
WIN_W, 3, window index width

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
swp_req_vld  in  1  swap request valid
swp_req_rdy  out  1  controller can accept a request
swp_tid  in  TID_W  thread of request
swp_old_win  in  WIN_W  window being saved
swp_new_win  in  WIN_W  window being restored
swp_kill  in  1  abort/flush from pipeline
irf_save  out  1  save strobe to IRF registers
irf_restore  out  1  restore strobe to IRF registers
irf_save_addr  out  TID_W+WIN_W  {tid, old_win}
irf_restore_addr  out  TID_W+WIN_W  {tid, new_win}
irf_bank_sel  out  BANKS  one-hot bank being operated on
swp_done  out  1  one-cycle completion pulse
swp_aborted  out  1  qualifies swp_done: swap was killed
swp_done_tid  out  TID_W  thread of completed swap
swp_busy_tid  out  2**TID_W  per-thread swap-in-progress mask

Behaviour:
- Reset: state IDLE, bank counter 0, all outputs 0 except swp_req_rdy=1. Reset mid-swap abandons the swap immediately. No done pulse is issued.
- swp_req_rdy = (state==IDLE) && !swp_kill. A request is accepted on vld&&rdy. tid/old/new are captured into registers; outputs come only from these registers.
- States: IDLE, SAVE, GAP, RESTORE, DONE.
- IDLE -> SAVE on accept. If old_win==new_win, the request is a no-op and IDLE -> DONE with swp_aborted=0. No save or restore is issued. This avoids the same-address restore hazard in the register.
- SAVE: irf_save=1, irf_bank_sel=1<<cnt. cnt increments each cycle. After cnt==BANKS-1, go to GAP with cnt=0.
- GAP: one idle cycle, all strobes 0. The window written on the previous negedge becomes visible as restore_data.
- RESTORE: irf_restore=1, irf_bank_sel=1<<cnt. After cnt==BANKS-1, go to DONE.
- DONE: swp_done=1, swp_done_tid=captured tid, then IDLE. swp_req_rdy returns high in the cycle after DONE.
- Latency, accept at cycle T:
  - save cycles T+1..T+BANKS
  - gap at T+BANKS+1
  - restore cycles T+BANKS+2..T+2*BANKS+1
  - done at T+2*BANKS+2
  - For BANKS=2: done at T+6.
- irf_save and irf_restore are never both 1. irf_bank_sel is 0 whenever neither strobe is high.
- Kill:
  - Ignored during SAVE; a partial save would corrupt the backing store.
  - Kill in GAP or RESTORE: strobes drop next cycle, go to DONE with swp_aborted=1.
  - Kill in DONE: no effect.
  - Kill in IDLE blocks accept that cycle.
- swp_busy_tid[tid] is set from T+1 through the DONE cycle inclusive. At most one bit is set at a time.
- Addresses hold their captured values from T+1 through DONE and are 0 in IDLE.

Decomposition:
- Shared package bw_r_irf_pkg holds:
  - TID_W and WIN_W constants
  - swap state enum (IDLE, SAVE, GAP, RESTORE, DONE)
  - a function building the IRF address {tid, win}
- One sub-module, bw_r_irf_swap_bank_cnt: wrap-at-BANKS-1 counter with clear, enable, last flag and one-hot decode. It is shared by the SAVE and RESTORE phases.

Test Plan:
- Basic swap, BANKS=2, accept tid=1 old=3 new=4 at T -> irf_save at T+1 and T+2 with addr 0x0B and bank_sel 01 then 10; idle gap at T+3; irf_restore at T+4 and T+5 with addr 0x0C; swp_done, aborted=0, done_tid=1 at T+6; busy_tid=0010 from T+1 to T+6.
- No-op swap, tid=2 old=5 new=5 -> no save/restore strobes; swp_done at T+1 with aborted=0; rdy high at T+2.
- Kill during SAVE at T+1 -> both save cycles still issued and the swap completes normally. Kill at T+4 (RESTORE) -> irf_restore only at T+4; swp_done with aborted=1 at T+5.
- Back-to-back requests with vld held high -> second accepted in the cycle after done; rdy low from T+1 to T+6; kill asserted in IDLE holds off accept for one cycle.
- Reset asserted at T+3 (GAP) -> next cycle state IDLE, all strobes 0, busy=0, no swp_done, rdy=1.
- BANKS=1 and BANKS=8 sweeps -> done at T+4 and T+18 respectively; bank_sel walks one-hot 1..0x80 in both phases.
